// File: rtl/id_pkg.sv
// Shared decode constants and types for the instruction-decode stage.
package id_pkg;

    localparam logic [2:0] OP_CLASS_RALU = 3'b000;
    localparam logic [2:0] OP_CLASS_IALU = 3'b001;
    localparam logic [2:0] OP_CLASS_BR   = 3'b010;
    localparam logic [2:0] OP_CLASS_MEM  = 3'b011;

    localparam logic [5:0] OP_BE  = 6'b010000;
    localparam logic [5:0] OP_BNE = 6'b010001;
    localparam logic [5:0] OP_JMP = 6'b010010;
    localparam logic [5:0] OP_LDW = 6'b011000;
    localparam logic [5:0] OP_STW = 6'b011001;

    typedef enum logic [2:0] {
        ALU_AND, ALU_OR, ALU_XOR, ALU_ADDS, ALU_ADDU, ALU_SUBS, ALU_SHRL, ALU_SHLL
    } alu_op_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    // Arithmetic ops take a sign-extended immediate, logic/shift ops a zero-extended one.
    function automatic logic imm_is_signed(input alu_op_t op);
        return (op == ALU_ADDS) || (op == ALU_ADDU) || (op == ALU_SUBS);
    endfunction

endpackage

// File: rtl/id_if.sv
// ID->EX pipeline register bus; id_stage drives it, execute consumes it.
interface id_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    import id_pkg::*;

    logic [ADDR_W-1:0] id_pc;
    logic              id_en;
    alu_op_t           id_alu_op;
    logic [DATA_W-1:0] id_alu_in_0;
    logic [DATA_W-1:0] id_alu_in_1;
    mem_op_t           id_mem_op;
    logic [DATA_W-1:0] id_mem_wr_data;
    logic [4:0]        id_dst_addr;
    logic              id_gpr_we;
    logic              id_undef;

    modport master (
        output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1,
               id_mem_op, id_mem_wr_data, id_dst_addr, id_gpr_we, id_undef
    );
    modport slave (
        input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1,
               id_mem_op, id_mem_wr_data, id_dst_addr, id_gpr_we, id_undef
    );
endinterface

// File: rtl/id_decoder.sv
// Combinational decode: instruction + forwarded operands -> execute fields, branch target/condition.
module id_decoder
    import id_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output alu_op_t           alu_op,
    output logic [DATA_W-1:0] alu_in_0,
    output logic [DATA_W-1:0] alu_in_1,
    output mem_op_t           mem_op,
    output logic [DATA_W-1:0] wr_data,
    output logic [4:0]        dst_addr,
    output logic              gpr_we,
    output logic              undef,
    output logic              uses_ra,
    output logic              uses_rb,
    output logic              br_cond,
    output logic [ADDR_W-1:0] br_target
);
    logic [5:0]        op;
    logic [DATA_W-1:0] imm_s, imm_z;

    assign op    = instr[31:26];
    assign imm_s = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign imm_z = {{(DATA_W-16){1'b0}}, instr[15:0]};

    always_comb begin
        alu_op    = ALU_AND;
        alu_in_0  = '0;
        alu_in_1  = '0;
        mem_op    = MEM_NONE;
        wr_data   = '0;
        dst_addr  = '0;
        gpr_we    = 1'b0;
        undef     = 1'b0;
        uses_ra   = 1'b0;
        uses_rb   = 1'b0;
        br_cond   = 1'b0;
        br_target = if_pc + imm_s[ADDR_W-1:0];
        if (op[5:3] == OP_CLASS_RALU) begin
            alu_op   = alu_op_t'(op[2:0]);
            alu_in_0 = opa;
            alu_in_1 = opb;
            dst_addr = instr[15:11];
            gpr_we   = 1'b1;
            uses_ra  = 1'b1;
            uses_rb  = 1'b1;
        end else if (op[5:3] == OP_CLASS_IALU) begin
            alu_op   = alu_op_t'(op[2:0]);
            alu_in_0 = opa;
            alu_in_1 = imm_is_signed(alu_op_t'(op[2:0])) ? imm_s : imm_z;
            dst_addr = instr[20:16];
            gpr_we   = 1'b1;
            uses_ra  = 1'b1;
        end else begin
            case (op)
                OP_BE, OP_BNE: begin
                    uses_ra = 1'b1;
                    uses_rb = 1'b1;
                    br_cond = (opa == opb) ^ (op == OP_BNE);
                end
                OP_JMP: begin
                    uses_ra   = 1'b1;
                    br_cond   = 1'b1;
                    br_target = opa[ADDR_W+1:2];
                end
                OP_LDW: begin
                    mem_op   = MEM_LOAD;
                    alu_op   = ALU_ADDU;
                    alu_in_0 = opa;
                    alu_in_1 = imm_s;
                    dst_addr = instr[20:16];
                    gpr_we   = 1'b1;
                    uses_ra  = 1'b1;
                end
                OP_STW: begin
                    mem_op   = MEM_STORE;
                    alu_op   = ALU_ADDU;
                    alu_in_0 = opa;
                    alu_in_1 = imm_s;
                    wr_data  = opb;
                    uses_ra  = 1'b1;
                    uses_rb  = 1'b1;
                end
                default: undef = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/id_stage.sv
// Decode stage: operand forwarding, load-use hazard, branch resolution and the ID pipeline register.
module id_stage
    import id_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_instruction,
    input  logic              if_en,
    output logic [4:0]        gpr_rd_addr_0,
    output logic [4:0]        gpr_rd_addr_1,
    input  logic [DATA_W-1:0] gpr_rd_data_0,
    input  logic [DATA_W-1:0] gpr_rd_data_1,
    input  logic              ex_fwd_en,
    input  logic [4:0]        ex_dst_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              ex_is_load,
    input  logic              mem_fwd_en,
    input  logic [4:0]        mem_dst_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_addr,
    output logic              ld_hazard,
    id_if.master              id_bus
);
    logic [1:0][4:0]        rd_addr;
    logic [1:0][DATA_W-1:0] rd_data, opnd;
    logic [1:0]             rd_used;

    alu_op_t           d_alu_op;
    mem_op_t           d_mem_op;
    logic [DATA_W-1:0] d_in_0, d_in_1, d_wr_data;
    logic [4:0]        d_dst;
    logic              d_we, d_undef, d_cond;

    assign rd_addr       = {if_instruction[20:16], if_instruction[25:21]};
    assign rd_data       = {gpr_rd_data_1, gpr_rd_data_0};
    assign gpr_rd_addr_0 = rd_addr[0];
    assign gpr_rd_addr_1 = rd_addr[1];

    // EX is younger than MEM, so it wins when both target the same register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign opnd[gi] = (ex_fwd_en  && ex_dst_addr  == rd_addr[gi]) ? ex_fwd_data  :
                          (mem_fwd_en && mem_dst_addr == rd_addr[gi]) ? mem_fwd_data :
                          rd_data[gi];
    end

    id_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dec (
        .instr     (if_instruction),
        .if_pc     (if_pc),
        .opa       (opnd[0]),
        .opb       (opnd[1]),
        .alu_op    (d_alu_op),
        .alu_in_0  (d_in_0),
        .alu_in_1  (d_in_1),
        .mem_op    (d_mem_op),
        .wr_data   (d_wr_data),
        .dst_addr  (d_dst),
        .gpr_we    (d_we),
        .undef     (d_undef),
        .uses_ra   (rd_used[0]),
        .uses_rb   (rd_used[1]),
        .br_cond   (d_cond),
        .br_target (br_addr)
    );

    assign ld_hazard = if_en && ex_is_load && ex_fwd_en &&
                       ((rd_used[0] && ex_dst_addr == rd_addr[0]) ||
                        (rd_used[1] && ex_dst_addr == rd_addr[1]));
    assign br_taken  = if_en && !ld_hazard && !stall && d_cond;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || (!stall && (flush || ld_hazard || !if_en))) begin
            id_bus.id_pc          <= '0;
            id_bus.id_en          <= 1'b0;
            id_bus.id_alu_op      <= ALU_AND;
            id_bus.id_alu_in_0    <= '0;
            id_bus.id_alu_in_1    <= '0;
            id_bus.id_mem_op      <= MEM_NONE;
            id_bus.id_mem_wr_data <= '0;
            id_bus.id_dst_addr    <= '0;
            id_bus.id_gpr_we      <= 1'b0;
            id_bus.id_undef       <= 1'b0;
        end else if (!stall) begin
            id_bus.id_pc          <= if_pc;
            id_bus.id_en          <= 1'b1;
            id_bus.id_alu_op      <= d_alu_op;
            id_bus.id_alu_in_0    <= d_in_0;
            id_bus.id_alu_in_1    <= d_in_1;
            id_bus.id_mem_op      <= d_mem_op;
            id_bus.id_mem_wr_data <= d_wr_data;
            id_bus.id_dst_addr    <= d_dst;
            id_bus.id_gpr_we      <= d_we;
            id_bus.id_undef       <= d_undef;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Randomized + directed bench for id_stage against a behavioural decode model.
module tb_id_stage;
    import id_pkg::*;
    localparam int AW = 30;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          stall = 0, flush = 0, if_en = 0;
    logic [AW-1:0] if_pc = '0;
    logic [DW-1:0] if_instruction = '0;
    logic [4:0]    gpr_rd_addr_0, gpr_rd_addr_1;
    logic [DW-1:0] gpr_rd_data_0, gpr_rd_data_1;
    logic          ex_fwd_en = 0, ex_is_load = 0, mem_fwd_en = 0;
    logic [4:0]    ex_dst_addr = '0, mem_dst_addr = '0;
    logic [DW-1:0] ex_fwd_data = '0, mem_fwd_data = '0;
    logic          br_taken, ld_hazard;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] rf [32];

    assign gpr_rd_data_0 = rf[gpr_rd_addr_0];
    assign gpr_rd_data_1 = rf[gpr_rd_addr_1];

    id_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    id_stage #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_pc(if_pc), .if_instruction(if_instruction), .if_en(if_en),
        .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
        .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
        .ex_fwd_en(ex_fwd_en), .ex_dst_addr(ex_dst_addr), .ex_fwd_data(ex_fwd_data),
        .ex_is_load(ex_is_load), .mem_fwd_en(mem_fwd_en), .mem_dst_addr(mem_dst_addr),
        .mem_fwd_data(mem_fwd_data), .br_taken(br_taken), .br_addr(br_addr),
        .ld_hazard(ld_hazard), .id_bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Expected ID register contents; c_* mark fields the instruction defines.
    logic [AW-1:0] e_pc;
    logic          e_en, e_we, e_undef, c_alu, c_dst, c_wd;
    logic [2:0]    e_alu;
    logic [1:0]    e_mem;
    logic [DW-1:0] e_in0, e_in1, e_wd;
    logic [4:0]    e_dst;

    task automatic set_bubble();
        e_pc = '0; e_en = 0; e_we = 0; e_undef = 0; e_alu = 0; e_mem = 0;
        e_in0 = '0; e_in1 = '0; e_wd = '0; e_dst = '0;
        c_alu = 1; c_dst = 1; c_wd = 1;
    endtask

    task automatic check_id(input string t);
        chk({t, ".en"},    64'(bus.id_en), 64'(e_en));
        chk({t, ".pc"},    64'(bus.id_pc), 64'(e_pc));
        chk({t, ".we"},    64'(bus.id_gpr_we), 64'(e_we));
        chk({t, ".mem"},   64'(bus.id_mem_op), 64'(e_mem));
        chk({t, ".undef"}, 64'(bus.id_undef), 64'(e_undef));
        if (c_alu) begin
            chk({t, ".alu"}, 64'(bus.id_alu_op), 64'(e_alu));
            chk({t, ".in0"}, 64'(bus.id_alu_in_0), 64'(e_in0));
            chk({t, ".in1"}, 64'(bus.id_alu_in_1), 64'(e_in1));
        end
        if (c_dst) chk({t, ".dst"}, 64'(bus.id_dst_addr), 64'(e_dst));
        if (c_wd)  chk({t, ".wd"},  64'(bus.id_mem_wr_data), 64'(e_wd));
    endtask

    function automatic logic [DW-1:0] fwd(input logic [4:0] a);
        if (ex_fwd_en && ex_dst_addr == a) return ex_fwd_data;
        if (mem_fwd_en && mem_dst_addr == a) return mem_fwd_data;
        return rf[a];
    endfunction

    // Drive one cycle of IF inputs (forwarding/rf already set), check the
    // combinational outputs, then the ID register after the edge.
    task automatic step(input string t, input logic [31:0] ins, input logic [AW-1:0] pc,
                        input logic en, input logic st, input logic fl);
        logic [5:0] op;
        logic [4:0] ra, rb, rc;
        logic [DW-1:0] a, b, sx, zx;
        logic [AW-1:0] tgt;
        logic ua, ub, cond, is_br, haz;
        logic [2:0] alu;
        logic [1:0] mem;
        logic [DW-1:0] in0, in1, wd;
        logic [4:0] dst;
        logic we, und, ca, cd, cw;
        if_instruction = ins; if_pc = pc; if_en = en; stall = st; flush = fl;
        #2;
        op = ins[31:26]; ra = ins[25:21]; rb = ins[20:16]; rc = ins[15:11];
        a = fwd(ra); b = fwd(rb);
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        tgt = pc + sx[AW-1:0];
        ua = 0; ub = 0; cond = 0; is_br = 0; alu = 0; mem = 0; in0 = 0; in1 = 0;
        wd = 0; dst = 0; we = 0; und = 0; ca = 0; cd = 0; cw = 0;
        if (op < 6'd8) begin
            alu = op[2:0]; in0 = a; in1 = b; dst = rc; we = 1; ua = 1; ub = 1; ca = 1; cd = 1;
        end else if (op < 6'd16) begin
            alu = op[2:0]; in0 = a; dst = rb; we = 1; ua = 1; ca = 1; cd = 1;
            in1 = (alu >= 3 && alu <= 5) ? sx : zx;
        end else if (op == 6'd16 || op == 6'd17) begin
            ua = 1; ub = 1; is_br = 1;
            cond = (op == 6'd16) ? (a == b) : (a != b);
        end else if (op == 6'd18) begin
            ua = 1; is_br = 1; cond = 1; tgt = a[31:2];
        end else if (op == 6'd24) begin
            mem = 1; alu = 4; in0 = a; in1 = sx; dst = rb; we = 1; ua = 1; ca = 1; cd = 1;
        end else if (op == 6'd25) begin
            mem = 2; alu = 4; in0 = a; in1 = sx; wd = b; ua = 1; ub = 1; ca = 1; cw = 1;
        end else begin
            und = 1;
        end
        haz = en && ex_is_load && ex_fwd_en &&
              ((ua && ex_dst_addr == ra) || (ub && ex_dst_addr == rb));
        chk({t, ".rd0"}, 64'(gpr_rd_addr_0), 64'(ra));
        chk({t, ".rd1"}, 64'(gpr_rd_addr_1), 64'(rb));
        chk({t, ".haz"}, 64'(ld_hazard), 64'(haz));
        chk({t, ".taken"}, 64'(br_taken), 64'(en && !haz && !st && cond));
        if (is_br) chk({t, ".target"}, 64'(br_addr), 64'(tgt));
        if (!st) begin
            if (fl || haz || !en) set_bubble();
            else begin
                e_pc = pc; e_en = 1; e_alu = alu; e_in0 = in0; e_in1 = in1; e_mem = mem;
                e_wd = wd; e_dst = dst; e_we = we; e_undef = und;
                c_alu = ca; c_dst = cd; c_wd = cw;
            end
        end
        @(posedge clk);
        #1;
        check_id(t);
    endtask

    task automatic mid_reset();
        rst = 1'b0;
        #1;
        set_bubble();
        check_id("rst_async");
        @(posedge clk);
        #1;
        check_id("rst_hold");
        rst = 1'b1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    initial begin
        logic [5:0] op;
        logic [5:0] undef_ops [4];
        undef_ops = '{6'b111111, 6'b010011, 6'b011010, 6'b100101};
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        #12;
        set_bubble();
        check_id("reset");
        rst = 1'b1;

        rf[1] = 32'd5; rf[2] = 32'd7;
        step("addur", mk(6'b000100, 5'd1, 5'd2, 16'h1800), 30'h40, 1, 0, 0);

        ex_fwd_en = 1; ex_dst_addr = 5'd1; ex_fwd_data = 32'hA;
        mem_fwd_en = 1; mem_dst_addr = 5'd1; mem_fwd_data = 32'hB;
        step("addui_fwd", mk(6'b001100, 5'd1, 5'd4, 16'hFFFF), 30'h41, 1, 0, 0);
        ex_fwd_en = 0; mem_fwd_en = 0;

        rf[2] = 32'd5;
        step("be_eq", mk(6'b010000, 5'd1, 5'd2, 16'hFFF0), 30'h100, 1, 0, 0);
        rf[2] = 32'd6;
        step("be_ne", mk(6'b010000, 5'd1, 5'd2, 16'hFFF0), 30'h100, 1, 0, 0);
        rf[3] = 32'h0000_0404;
        step("jmp", mk(6'b010010, 5'd3, 5'd0, 16'h0), 30'h55, 1, 0, 0);

        ex_fwd_en = 1; ex_is_load = 1; ex_dst_addr = 5'd1; ex_fwd_data = 32'h99;
        step("ldhaz", mk(6'b000100, 5'd1, 5'd2, 16'h1800), 30'h60, 1, 0, 0);
        ex_is_load = 0;
        step("ldhaz_clr", mk(6'b000100, 5'd1, 5'd2, 16'h1800), 30'h60, 1, 0, 0);
        ex_fwd_en = 0;

        step("stall_flush", mk(6'b011001, 5'd2, 5'd3, 16'h8), 30'h61, 1, 1, 1);
        step("flush", mk(6'b011001, 5'd2, 5'd3, 16'h8), 30'h62, 1, 0, 1);
        step("undef", mk(6'b111111, 5'd2, 5'd3, 16'h8), 30'h63, 1, 0, 0);
        step("ldw", mk(6'b011000, 5'd2, 5'd7, 16'h8004), 30'h64, 1, 0, 0);
        mid_reset();
        step("post_rst", mk(6'b000010, 5'd2, 5'd3, 16'h2000), 30'h65, 1, 0, 0);

        for (int n = 0; n < 400; n++) begin
            int k;
            if (n % 8 == 0) rf[$urandom_range(0, 3)] = $urandom_range(0, 3);
            ex_fwd_en    = ($urandom_range(0, 2) == 0);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_dst_addr  = 5'($urandom_range(0, 3));
            ex_fwd_data  = $urandom_range(0, 3);
            mem_fwd_en   = ($urandom_range(0, 2) == 0);
            mem_dst_addr = 5'($urandom_range(0, 3));
            mem_fwd_data = $urandom;
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: op = {3'b000, 3'($urandom)};
                3, 4:    op = {3'b001, 3'($urandom)};
                5:       op = 6'b010000 | 6'($urandom_range(0, 1));
                6:       op = 6'b010010;
                7:       op = 6'b011000;
                8:       op = 6'b011001;
                default: op = undef_ops[$urandom_range(0, 3)];
            endcase
            if (n == 200) mid_reset();
            step("rand", mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)),
                 30'($urandom), ($urandom_range(0, 6) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage, directly downstream of the fetch stage. Consumes the fetched `if_pc`, `if_instruction` and `if_en` registers and decodes the instruction. Reads the general-purpose register file, applies EX/MEM forwarding, resolves branches back to fetch, and detects load-use hazards. Results are latched into the `id_*` pipeline register consumed by the execute stage.

## Interface
Parameters:
- `ADDR_W`, default 30: word-address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the ID pipeline register.
- `flush`  in  1  replace the next ID contents with a bubble.
- `if_pc`  in  ADDR_W  PC of the instruction after the one in `if_instruction`.
- `if_instruction`  in  DATA_W  fetched instruction.
- `if_en`  in  1  `if_instruction` is valid.
- `gpr_rd_addr_0`, `gpr_rd_addr_1`  out  5  register-file read addresses; the register file reads combinationally.
- `gpr_rd_data_0`, `gpr_rd_data_1`  in  DATA_W  register-file read data.
- `ex_fwd_en`, `ex_dst_addr`, `ex_fwd_data`, `ex_is_load`  in  1/5/DATA_W/1  EX-stage result forwarding.
- `mem_fwd_en`, `mem_dst_addr`, `mem_fwd_data`  in  1/5/DATA_W  MEM-stage result forwarding.
- `br_taken`  out  1  redirect fetch (combinational).
- `br_addr`  out  ADDR_W  redirect target (combinational).
- `ld_hazard`  out  1  load-use stall request to the pipeline controller (combinational).
- `id_pc`, `id_en`  out  ADDR_W/1  pipeline register: PC and valid.
- `id_alu_op`  out  3  pipeline register: ALU operation.
- `id_alu_in_0`, `id_alu_in_1`  out  DATA_W  pipeline register: ALU operands.
- `id_mem_op`  out  2  pipeline register: memory operation.
- `id_mem_wr_data`  out  DATA_W  pipeline register: store data.
- `id_dst_addr`  out  5  pipeline register: destination register.
- `id_gpr_we`  out  1  pipeline register: register write enable.
- `id_undef`  out  1  pipeline register: undefined-opcode flag.

## Operation

Instruction fields:
- op = [31:26], ra = [25:21], rb = [20:16], rc = [15:11], imm = [15:0].
- `gpr_rd_addr_0` = ra; `gpr_rd_addr_1` = rb.

Operand forwarding (per read port):
- If `ex_fwd_en` is set and `ex_dst_addr` matches the port address, use `ex_fwd_data`.
- Otherwise, if `mem_fwd_en` is set and `mem_dst_addr` matches, use `mem_fwd_data`.
- Otherwise use the register-file data.
- r0 is an ordinary register and is forwarded like any other.

Decode:
- op[5:3]=000, R-type ALU:
  - alu_op = op[2:0] (0 AND, 1 OR, 2 XOR, 3 ADDS, 4 ADDU, 5 SUBS, 6 SHRL, 7 SHLL).
  - in0 = fwd ra, in1 = fwd rb, dst = rc, gpr_we = 1.
- op[5:3]=001, I-type ALU:
  - Same alu_op mapping; in1 = imm.
  - imm is zero-extended for alu_op 0–2 and 6–7, sign-extended for 3–5.
  - dst = rb, gpr_we = 1.
- op=010000 BE, op=010001 BNE:
  - Compare fwd ra with fwd rb.
  - Target = if_pc + sext(imm), modulo 2^ADDR_W.
  - gpr_we = 0.
- op=010010 JMP:
  - Target = fwd ra[ADDR_W+1:2].
  - Always taken; gpr_we = 0.
- op=011000 LDW:
  - mem_op = LOAD, alu_op = ADDU, in0 = fwd ra, in1 = sext(imm).
  - dst = rb, gpr_we = 1.
- op=011001 STW:
  - mem_op = STORE, alu_op = ADDU, in0 = fwd ra, in1 = sext(imm), wr_data = fwd rb.
  - gpr_we = 0.
- Any other op:
  - id_undef = 1; treated as a NOP (gpr_we = 0, mem_op = NONE).

Load-use hazard:
- `ld_hazard` = if_en & ex_is_load & ex_fwd_en & (ex_dst_addr equals a register the instruction reads).
- Register-read uses: R-type reads ra and rb; I-type reads ra; branches read ra and rb; JMP reads ra; LDW reads ra; STW reads ra and rb.

Branch outputs:
- `br_taken` is asserted only when if_en & !ld_hazard & !stall and the branch condition holds.
- `br_addr` is always driven with the computed target.

## Timing
- Reset (rst=0, asynchronous): every `id_*` output goes to 0. This means id_en=0, gpr_we=0, mem_op=NONE (0), undef=0.
- Decode-to-register latency: 1 cycle. The instruction presented with if_en=1 in cycle N appears on `id_*` in cycle N+1.
- Per-edge update priority:
  - stall=1: hold all `id_*` outputs. stall has priority over flush.
  - Otherwise flush=1 or ld_hazard=1: load a bubble (all fields 0).
  - Otherwise: load the decoded fields, with id_en = if_en.
- With if_en=0, the register loads a bubble and `br_taken`/`ld_hazard` stay 0.
- `br_taken`, `br_addr`, `ld_hazard` and `gpr_rd_addr_*` are combinational, valid in the same cycle as `if_instruction`.
- Reset deasserting mid-operation: the first edge after release loads normally.

## Structure
- Package `id_pkg` holds:
  - opcode localparams;
  - `alu_op_t` (3-bit) and `mem_op_t` (2 bits: NONE=0, LOAD=1, STORE=2);
  - the `OP_CLASS_*` constants.
- Sub-module `id_decoder`, combinational: maps instruction + forwarded operands + if_pc to decoded fields, the branch target and a taken condition.
- `id_stage` holds:
  - the forwarding muxes;
  - hazard detection;
  - branch gating;
  - the pipeline register.

## Test plan
- Reset then ADDUR r3=r1+r2 with r1=5, r2=7 → next cycle id_alu_in_0=5, id_alu_in_1=7, id_dst_addr=3, id_gpr_we=1, id_en=1.
- EX forwarding r1=0xA and MEM forwarding r1=0xB with ADDUI r4=r1+0xFFFF → id_alu_in_0=0xA (EX wins), id_alu_in_1=0xFFFFFFFF.
- BE r1,r2 equal, if_pc=0x100, imm=0xFFF0 → br_taken=1, br_addr=0xF0. Same with r2 differing → br_taken=0.
- ex_is_load with dst=r1, then ADDUR reading r1 → ld_hazard=1, br_taken=0, next id_en=0. Hazard clears the following cycle.
- stall=1 and flush=1 together → `id_*` outputs held unchanged. flush alone → id_en=0, id_gpr_we=0.
- op=111111 → id_undef=1, id_gpr_we=0, id_mem_op=NONE. Asserting rst mid-stream clears all `id_*` outputs immediately.
